aes_cpa_sequencer: RTL

AES_CPA_SEQUENCER -- requirements
Module: aes_cpa_sequencer

---
 rtl/aes_cpa_pkg.sv | 18 +
 rtl/aes_cpa_sequencer_if.sv | 26 ++
 rtl/aes_cpa_sequencer_timer.sv | 29 ++
 rtl/aes_cpa_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/aes_cpa_pkg.sv
// Shared types and defaults for the AES CPA trace-acquisition sequencer.
package aes_cpa_pkg;

    localparam int TIMER_W         = 16;
    localparam int AES_LATENCY_DEF = 11;
    localparam int GAP_CYCLES_DEF  = 16;
    localparam int TRIG_LEN_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPTURE,
        ST_GAP,
        ST_DONE
    } cpa_state_e;

endpackage

// File: rtl/aes_cpa_sequencer_if.sv
// Control/data bundle between the sequencer (master) and the AES core / host side (slave).
interface aes_cpa_sequencer_if #(
    parameter int CYPHER_SIZE = 128
);
    logic                   start;
    logic                   abort;
    logic [CYPHER_SIZE-1:0] cypher_in;
    logic                   aes_rst;
    logic                   aes_ena;
    logic [7:0]             pt_idx;
    logic                   trig;
    logic [CYPHER_SIZE-1:0] ct_q;
    logic                   ct_valid;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, abort, cypher_in,
        output aes_rst, aes_ena, pt_idx, trig, ct_q, ct_valid, busy, done
    );

    modport slave (
        output start, abort, cypher_in,
        input  aes_rst, aes_ena, pt_idx, trig, ct_q, ct_valid, busy, done
    );
endinterface

// File: rtl/aes_cpa_sequencer_timer.sv
// cpa_cycle_timer: loadable 16-bit down-counter that stops at zero; times both RUN and GAP.
module cpa_cycle_timer
    import aes_cpa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic [TIMER_W-1:0] cnt_o,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TIMER_W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aes_cpa_sequencer.sv
// AES CPA campaign sequencer: steps the AES core through NUM_TRACES encryptions,
// fires a scope trigger at the start of each and captures every ciphertext.
// Build option: define CPA_FREERUN_EN to wrap to index 0 at the end of a campaign
// and keep running until abort (done never asserts).
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | core held in reset, table index presented
// RUN     | core enabled for AES_LATENCY cycles, trigger in the first TRIG_LEN
// CAPTURE | ciphertext sampled into ct_q
// GAP     | idle spacing of GAP_CYCLES between encryptions
// DONE    | campaign finished, results held
module aes_cpa_sequencer
    import aes_cpa_pkg::*;
#(
    parameter int CYPHER_SIZE = 128,
    parameter int AES_LATENCY = AES_LATENCY_DEF,
    parameter int NUM_TRACES  = 256,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int TRIG_LEN    = TRIG_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    aes_cpa_sequencer_if.master bus
);

    localparam logic [TIMER_W-1:0] RUN_LOAD = TIMER_W'(AES_LATENCY - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
    // Timer counts AES_LATENCY-1 down to 0 in RUN; the first TRIG_LEN cycles sit at or above this.
    localparam logic [TIMER_W-1:0] TRIG_THR = TIMER_W'(AES_LATENCY - TRIG_LEN);
    localparam logic [7:0]         LAST_IDX = 8'(NUM_TRACES - 1);

    cpa_state_e             state_q, state_d;
    logic [7:0]             pt_idx_q, pt_idx_d;
    logic [CYPHER_SIZE-1:0] ct_q_q;
    logic                   ct_valid_q;
    logic                   capture;
    logic                   tmr_load;
    logic [TIMER_W-1:0]     tmr_val;
    logic [TIMER_W-1:0]     tmr_cnt;
    logic                   tmr_zero;

    cpa_cycle_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .cnt_o     (tmr_cnt),
        .zero_o    (tmr_zero)
    );

    // State, index and capture registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pt_idx_q   <= '0;
            ct_q_q     <= '0;
            ct_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pt_idx_q   <= pt_idx_d;
            ct_valid_q <= capture;
            if (capture) begin
                ct_q_q <= bus.cypher_in;
            end
        end
    end

    // Next-state, index update and timer control; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        pt_idx_d = pt_idx_q;
        tmr_load = 1'b0;
        tmr_val  = RUN_LOAD;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_LOAD;
                    pt_idx_d = '0;
                end
            end
            ST_LOAD: begin
                state_d  = ST_RUN;
                tmr_load = 1'b1;
                tmr_val  = RUN_LOAD;
            end
            ST_RUN: begin
                if (tmr_zero) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d  = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = GAP_LOAD;
                capture  = 1'b1;
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (pt_idx_q == LAST_IDX) begin
`ifdef CPA_FREERUN_EN
                        state_d  = ST_LOAD;
                        pt_idx_d = '0;
`else
                        state_d  = ST_DONE;
`endif
                    end else begin
                        state_d  = ST_LOAD;
                        pt_idx_d = pt_idx_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_d  = ST_IDLE;
            pt_idx_d = pt_idx_q;
            tmr_load = 1'b0;
            capture  = 1'b0;
        end
    end

    assign bus.aes_rst  = !((state_q == ST_RUN) || (state_q == ST_CAPTURE));
    assign bus.aes_ena  = (state_q == ST_RUN) && !bus.abort;
    assign bus.trig     = (state_q == ST_RUN) && (tmr_cnt >= TRIG_THR) && !bus.abort;
    assign bus.pt_idx   = pt_idx_q;
    assign bus.ct_q     = ct_q_q;
    assign bus.ct_valid = ct_valid_q;
    assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done     = (state_q == ST_DONE);

endmodule
